// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// One operation in flight: IDLE grant, EXEC on the ALU, RESP held until accepted.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0] req_sel,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_sel,
  input  logic [31:0]       alu_f,
  input  logic              alu_overflow,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_f,
  output logic              rsp_overflow,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t       state;
  state_t       state_d;
  logic [1:0]   ptr;
  logic [1:0]   g;
  logic [1:0]   gnt_idx;
  logic [1:0]   idx;
  logic         gnt_any;
  logic         take;
  logic         ack;
  logic         legal;
  logic [3:0]   vld4;
  logic [3:0]   rsp4;
  logic [3:0]   rdy4;
  logic [3:0]   rv4;
  logic [127:0] a4;
  logic [127:0] b4;
  logic [15:0]  s4;

  function automatic logic [1:0] wrap(input int v);
    return (v >= NREQ) ? 2'(v - NREQ) : 2'(v);
  endfunction

  // Pad per-requester buses to four slots so indexing by a 2-bit index is uniform
  assign vld4 = 4'(req_valid);
  assign rsp4 = 4'(rsp_ready);
  assign a4   = 128'(req_a);
  assign b4   = 128'(req_b);
  assign s4   = 16'(req_sel);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap(int'(ptr) + k);
      if (!gnt_any && vld4[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign take      = (state == IDLE) && gnt_any && rst_n;
  assign rdy4      = take ? (4'b0001 << gnt_idx) : 4'b0000;
  assign req_ready = rdy4[NREQ-1:0];

  assign ack       = rsp4[g];
  assign rv4       = (state == RESP) ? (4'b0001 << g) : 4'b0000;
  assign rsp_valid = rv4[NREQ-1:0];

  assign legal = (alu_sel != 4'd0) && (alu_sel <= 4'd8);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (take) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      g       <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 4'd1;
    end else if (take) begin
      ptr     <= wrap(int'(gnt_idx) + 1);
      g       <= gnt_idx;
      alu_a   <= a4[{gnt_idx, 5'd0} +: 32];
      alu_b   <= b4[{gnt_idx, 5'd0} +: 32];
      alu_sel <= s4[{gnt_idx, 2'd0} +: 4];
    end
  end

  // The ALU leaves result and carry undefined outside codes 1..8 and 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_f        <= '0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (state == EXEC) begin
      rsp_f        <= legal ? alu_f : 32'd0;
      rsp_overflow <= alu_overflow & (alu_sel == 4'd1);
      rsp_err      <= !legal;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NREQ=2.
// Includes a behavioural ALU that returns junk on illegal codes.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_f;
  logic        alu_overflow;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_f;
  logic        rsp_overflow;
  logic        rsp_err;

  int nvec;
  int nerr;

  alu_arbiter #(.NREQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_f        (alu_f),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_f        (rsp_f),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_f        = 32'hDEAD_BEEF;
    alu_overflow = 1'b1;
    case (alu_sel)
      4'd1: {alu_overflow, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2: begin
        alu_f        = alu_a - alu_b;
        alu_overflow = alu_a < alu_b;
      end
      4'd3: alu_f = alu_a & alu_b;
      4'd4: alu_f = alu_a | alu_b;
      4'd5: alu_f = alu_a ^ alu_b;
      4'd6: alu_f = alu_a >> alu_b[4:0];
      4'd7: alu_f = alu_a >> alu_b[4:0];
      4'd8: alu_f = alu_a << alu_b[4:0];
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int r, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] sel);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_sel[4*r +: 4] = sel;
  endtask

  // Starts in IDLE, mid-cycle, with no competing request
  task automatic run_op(input string tag, input int r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] ef,
                        input logic eo, input logic ee);
    load(r, a, b, sel);
    req_valid = 2'(1 << r);
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << r));
    cyc;
    req_valid = 2'b00;
    #1;
    chk({tag, "_sel"}, 32'(alu_sel), 32'(sel));
    chk({tag, "_exv"}, 32'(rsp_valid), 32'd0);
    cyc;
    #1;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(1 << r));
    chk({tag, "_f"}, rsp_f, ef);
    chk({tag, "_ov"}, 32'(rsp_overflow), 32'(eo));
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    cyc;
  endtask

  initial begin
    int ng;
    int last;
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 2'b11;

    #12;
    req_valid = 2'b01;
    #1;
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_sel", 32'(alu_sel), 32'd1);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_f", rsp_f, 32'd0);
    chk("rst_ov", 32'(rsp_overflow), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc;

    run_op("add", 0, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0, 1'b1, 1'b0);
    run_op("sub", 0, 32'd0, 32'd1, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("ill0", 0, 32'd5, 32'd3, 4'd0, 32'd0, 1'b0, 1'b1);
    run_op("ill9", 1, 32'd5, 32'd3, 4'd9, 32'd0, 1'b0, 1'b1);
    run_op("xor", 0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd5,
           32'h0000_FF00, 1'b0, 1'b0);
    run_op("srl", 0, 32'h8000_0000, 32'd4, 4'd7,
           32'h0800_0000, 1'b0, 1'b0);
    run_op("sll", 1, 32'd1, 32'd31, 4'd8, 32'h8000_0000, 1'b0, 1'b0);

    // ptr is now 0: continuous contention
    load(0, 32'd1, 32'd2, 4'd1);
    load(1, 32'd10, 32'd3, 4'd2);
    req_valid = 2'b11;
    ng   = 0;
    last = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("cont_both", 32'(req_ready == 2'b11), 32'd0);
      if (req_ready != 2'b00) begin
        chk("cont_gnt", 32'(req_ready), (ng % 2 == 0) ? 32'd1 : 32'd2);
        if (ng > 0) chk("cont_gap", 32'(i - last), 32'd3);
        last = i;
        ng++;
      end
      cyc;
    end
    chk("cont_count", 32'(ng), 32'd4);
    req_valid = 2'b00;
    cyc;
    cyc;

    // Response stall on requester 1 while requester 0 waits
    load(1, 32'h0000_F000, 32'h0000_000F, 4'd4);
    load(0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd3);
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1;
    chk("stall_gnt1", 32'(req_ready), 32'd2);
    cyc;
    req_valid = 2'b01;
    #1;
    chk("stall_exec_rdy", 32'(req_ready), 32'd0);
    cyc;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_vld", 32'(rsp_valid), 32'd2);
      chk("stall_f", rsp_f, 32'h0000_F00F);
      chk("stall_rdy0", 32'(req_ready), 32'd0);
      cyc;
    end
    rsp_ready = 2'b11;
    #1;
    chk("stall_last_rdy0", 32'(req_ready), 32'd0);
    cyc;
    #1;
    chk("stall_gnt0", 32'(req_ready), 32'd1);
    cyc;
    req_valid = 2'b00;
    cyc;
    #1;
    chk("stall_r0_vld", 32'(rsp_valid), 32'd1);
    chk("stall_r0_f", rsp_f, 32'h0F00_0F00);
    cyc;

    // ptr is now 1: reset during EXEC must return ptr to 0
    load(1, 32'd5, 32'd6, 4'd1);
    req_valid = 2'b10;
    #1;
    chk("mrst_gnt1", 32'(req_ready), 32'd2);
    cyc;
    #1;
    chk("mrst_exec_a", alu_a, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(rsp_valid), 32'd0);
    chk("mrst_rdy", 32'(req_ready), 32'd0);
    chk("mrst_a", alu_a, 32'd0);
    #2;
    rst_n = 1'b1;
    load(0, 32'd7, 32'd8, 4'd1);
    req_valid = 2'b11;
    #1;
    chk("mrst_gnt0", 32'(req_ready), 32'd1);
    cyc;
    req_valid = 2'b00;
    cyc;
    #1;
    chk("mrst_rvld", 32'(rsp_valid), 32'd1);
    chk("mrst_f", rsp_f, 32'd15);
    chk("mrst_err", 32'(rsp_err), 32'd0);
    cyc;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
